// File: rtl/lcd_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_cmd_seq
//  Description : Command sequencer in front of LCD_CTRL. Buffers 4-bit host
//                commands in a small FIFO and issues them one at a time as a
//                one-cycle cmd/cmd_valid strobe, honouring busy, until
//                LCD_CTRL reports done.
//                Optional feature macro: LCD_SEQ_STALL_CNT_EN adds stall_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_cmd_seq #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    in_cmd,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [3:0]    cmd,
    output logic          cmd_valid,
    input  logic          busy,
    input  logic          lcd_done,
    output logic [AW:0]   fifo_level,
    output logic [7:0]    issued_cnt,
    output logic          seq_done
`ifdef LCD_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    localparam int         LW       = AW + 1;
    localparam logic [AW:0] LVL_FULL = LW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GUARD = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic [3:0]      cmd_q, cmd_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic [7:0]      issued_cnt_q, issued_cnt_d;
    logic            seq_done_q, seq_done_d;
    logic [3:0]      mem_q [DEPTH];
    logic            push, pop;
`ifdef LCD_SEQ_STALL_CNT_EN
    logic [15:0]     stall_cnt_q, stall_cnt_d;
`endif

    // Ready depends only on the registered level, so a pop while full does
    // not open the input in the same cycle.
    assign in_ready   = (level_q != LVL_FULL);
    assign push       = in_valid && in_ready;
    assign cmd        = cmd_q;
    assign cmd_valid  = cmd_valid_q;
    assign fifo_level = level_q;
    assign issued_cnt = issued_cnt_q;
    assign seq_done   = seq_done_q;
`ifdef LCD_SEQ_STALL_CNT_EN
    assign stall_cnt  = stall_cnt_q;
`endif

    // Next-state logic for the issue FSM, FIFO pointers and counters.
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        cmd_d        = cmd_q;
        cmd_valid_d  = 1'b0;
        issued_cnt_d = issued_cnt_q;
        seq_done_d   = seq_done_q | lcd_done;

        case (state_q)
            S_IDLE: begin
                if (lcd_done) begin
                    state_d = S_FIN;
                end else if (!busy && (level_q != '0)) begin
                    state_d     = S_ISSUE;
                    pop         = 1'b1;
                    cmd_d       = mem_q[rd_ptr_q];
                    cmd_valid_d = 1'b1;
                end
            end
            S_ISSUE: begin
                // The strobe is already on the wire this cycle; done only
                // redirects where we go afterwards.
                if (issued_cnt_q != 8'hFF) begin
                    issued_cnt_d = issued_cnt_q + 8'd1;
                end
                state_d = lcd_done ? S_FIN : S_GUARD;
            end
            S_GUARD: begin
                // Gives LCD_CTRL a cycle to raise busy before it is sampled.
                state_d = lcd_done ? S_FIN : S_IDLE;
            end
            default: begin
                state_d = S_FIN;
            end
        endcase

        wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        level_d  = level_q + LW'(push) - LW'(pop);
    end

`ifdef LCD_SEQ_STALL_CNT_EN
    // Count cycles where work is pending but LCD_CTRL holds us off.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == S_IDLE) && (level_q != '0) && busy && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end
`endif

    // State and control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            cmd_q        <= 4'd0;
            cmd_valid_q  <= 1'b0;
            issued_cnt_q <= 8'd0;
            seq_done_q   <= 1'b0;
`ifdef LCD_SEQ_STALL_CNT_EN
            stall_cnt_q  <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            cmd_q        <= cmd_d;
            cmd_valid_q  <= cmd_valid_d;
            issued_cnt_q <= issued_cnt_d;
            seq_done_q   <= seq_done_d;
`ifdef LCD_SEQ_STALL_CNT_EN
            stall_cnt_q  <= stall_cnt_d;
`endif
        end
    end

    // FIFO storage; contents need no reset because the pointers discard them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_cmd;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_cmd_seq
//  Description : Self-checking bench for lcd_cmd_seq. Accepted pushes feed a
//                scoreboard queue; every issue strobe is checked against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_cmd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_cmd;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  cmd;
    logic        cmd_valid;
    logic        busy;
    logic        lcd_done;
    logic [2:0]  fifo_level;
    logic [7:0]  issued_cnt;
    logic        seq_done;
`ifdef LCD_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    logic [3:0]  sb [$];
    int          cyc = 0;
    int          last_issue = 0;
    int          last_gap = 0;
    bit          have_last = 1'b0;
    bit          no_issue = 1'b0;

    lcd_cmd_seq #(.DEPTH(4), .AW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_cmd     (in_cmd),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .busy       (busy),
        .lcd_done   (lcd_done),
        .fifo_level (fifo_level),
        .issued_cnt (issued_cnt),
        .seq_done   (seq_done)
`ifdef LCD_SEQ_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Issue monitor: every strobe must match the oldest accepted command.
    always @(negedge clk) begin
        cyc++;
        if (!rst && cmd_valid) begin
            if (no_issue || sb.size() == 0) begin
                chk("spurious_valid", 32'd1, 32'd0);
            end else begin
                chk("cmd_order", 32'(cmd), 32'(sb.pop_front()));
            end
            if (have_last) begin
                last_gap = cyc - last_issue;
                chk("spacing_ge3", 32'(last_gap >= 3), 32'd1);
            end
            last_issue = cyc;
            have_last  = 1'b1;
        end
    end

    // One cycle of host stimulus; records the command if it will be accepted.
    task automatic drive_cycle(input bit v, input logic [3:0] c, output bit acc);
        @(negedge clk);
        in_valid = v;
        in_cmd   = c;
        acc      = v && in_ready;
        if (acc) sb.push_back(c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        sb.delete();
        have_last = 1'b0;
        no_issue  = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && fifo_level == 3'd0 && !cmd_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_strobe(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cmd_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("strobe_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n_acc;
        int k;
        int max_lvl;
        logic [3:0] data;

        rst = 1'b1; in_cmd = 4'd0; in_valid = 1'b0; busy = 1'b0; lcd_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cmd",        32'(cmd),        32'd0);
        chk("rst_cmd_valid",  32'(cmd_valid),  32'd0);
        chk("rst_in_ready",   32'(in_ready),   32'd1);
        chk("rst_level",      32'(fifo_level), 32'd0);
        chk("rst_issued",     32'(issued_cnt), 32'd0);
        chk("rst_seq_done",   32'(seq_done),   32'd0);
        rst = 1'b0;

        // Idle: 20 cycles, any strobe is flagged by the monitor.
        repeat (20) @(negedge clk);
        chk("idle_issued", 32'(issued_cnt), 32'd0);

        // Back-to-back 3,5,1 with busy low; first strobe two edges after push.
        drive_cycle(1'b1, 4'd3, acc);
        drive_cycle(1'b1, 4'd5, acc);
        chk("latency_n1", 32'(cmd_valid), 32'd0);
        drive_cycle(1'b1, 4'd1, acc);
        chk("latency_n2", 32'(cmd_valid), 32'd1);
        drive_cycle(1'b0, 4'd0, acc);
        wait_drain(50);
        chk("t2_issued",  32'(issued_cnt), 32'd3);
        chk("t2_level",   32'(fifo_level), 32'd0);
        chk("t2_gap",     32'(last_gap),   32'd3);

        // Fill while busy: fifth push refused.
        busy  = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            data = 4'(9 + 3 * i);
            drive_cycle(1'b1, data, acc);
            n_acc += int'(acc);
        end
        drive_cycle(1'b0, 4'd0, acc);
        chk("full_accepted", 32'(n_acc),      32'd4);
        chk("full_in_ready", 32'(in_ready),   32'd0);
        chk("full_level",    32'(fifo_level), 32'd4);
        busy = 1'b0;
        wait_drain(60);
        chk("t3_issued", 32'(issued_cnt), 32'd7);

        // Continuous host stream: level saturates at 4, order survives wraps.
        k = 0; max_lvl = 0;
        for (int i = 0; i < 200 && k < 12; i++) begin
            data = 4'((k * 7 + 3) & 15);
            drive_cycle(1'b1, data, acc);
            k += int'(acc);
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
        end
        drive_cycle(1'b0, 4'd0, acc);
        wait_drain(100);
        chk("stream_count",  32'(k),          32'd12);
        chk("stream_maxlvl", 32'(max_lvl),    32'd4);
        chk("stream_issued", 32'(issued_cnt), 32'd19);

        // Done with two queued: enter FIN, nothing more issued, pushes still taken.
        busy = 1'b1;
        drive_cycle(1'b1, 4'd4, acc);
        drive_cycle(1'b1, 4'd8, acc);
        drive_cycle(1'b0, 4'd0, acc);
        chk("fin_pre_level", 32'(fifo_level), 32'd2);
        no_issue = 1'b1;
        sb.delete();
        lcd_done = 1'b1;
        @(negedge clk);
        lcd_done = 1'b0;
        chk("fin_seq_done", 32'(seq_done), 32'd1);
        busy = 1'b0;
        repeat (10) @(negedge clk);
        chk("fin_level",  32'(fifo_level), 32'd2);
        chk("fin_issued", 32'(issued_cnt), 32'd19);
        chk("fin_sticky", 32'(seq_done),   32'd1);
        drive_cycle(1'b1, 4'd5, acc);
        drive_cycle(1'b0, 4'd0, acc);
        chk("fin_push_level", 32'(fifo_level), 32'd3);

        // Done arriving during ISSUE: that strobe still completes.
        do_reset();
        drive_cycle(1'b1, 4'd11, acc);
        drive_cycle(1'b0, 4'd0, acc);
        wait_strobe(10);
        lcd_done = 1'b1;
        @(negedge clk);
        lcd_done = 1'b0;
        chk("issue_done_seq",   32'(seq_done),   32'd1);
        chk("issue_done_valid", 32'(cmd_valid),  32'd0);
        chk("issue_done_cnt",   32'(issued_cnt), 32'd1);
        chk("issue_done_cmd",   32'(cmd),        32'd11);
        no_issue = 1'b1;
        repeat (5) @(negedge clk);

        // Reset while in GUARD with three queued.
        do_reset();
        busy = 1'b1;
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 4'(i + 1), acc);
        drive_cycle(1'b0, 4'd0, acc);
        busy = 1'b0;
        wait_strobe(10);
        @(negedge clk);
        chk("guard_level", 32'(fifo_level), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_level",  32'(fifo_level), 32'd0);
        chk("mid_rst_issued", 32'(issued_cnt), 32'd0);
        chk("mid_rst_valid",  32'(cmd_valid),  32'd0);
        chk("mid_rst_ready",  32'(in_ready),   32'd1);
        rst = 1'b0;
        sb.delete();
        have_last = 1'b0;
        drive_cycle(1'b1, 4'd13, acc);
        drive_cycle(1'b0, 4'd0, acc);
        wait_drain(30);
        chk("post_rst_issued", 32'(issued_cnt), 32'd1);

`ifdef LCD_SEQ_STALL_CNT_EN
        do_reset();
        busy = 1'b1;
        drive_cycle(1'b1, 4'd6, acc);
        drive_cycle(1'b0, 4'd0, acc);
        repeat (10) @(negedge clk);
        chk("stall_cnt", 32'(stall_cnt), 32'd10);
        busy = 1'b0;
        wait_drain(30);
`endif

        // Issued counter saturates at 255.
        do_reset();
        k = 0;
        for (int i = 0; i < 1200 && k < 260; i++) begin
            data = 4'(k & 15);
            drive_cycle(1'b1, data, acc);
            k += int'(acc);
        end
        drive_cycle(1'b0, 4'd0, acc);
        wait_drain(100);
        chk("sat_issued", 32'(issued_cnt), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
